// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request/response bundle between core and data memory
// master : requester (drives mem_read, mem_write, addr, wdata; sees rdata, ready, busy, err)
// slave  : data_mem_responder (reverse directions)
interface data_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM responder with wait states and one-cycle ready/err pulse
// Ports: clk (rising edge), rst_n (async active-low), bus (data_mem_responder_if.slave:
//   mem_read/mem_write/addr/wdata in, rdata/ready/busy/err out).
// Parameters: DATA_W word width, DEPTH_LOG2 log2 words, WAIT_CYCLES extra wait cycles (0..15).
// Optional: MISALIGN_TRAP_EN rejects addr[1:0]!=0 with err instead of ignoring the low bits.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_responder_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_nxt;
    logic [3:0]            cnt_q;
    logic                  op_rd_q, op_wr_q, bad_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  ready_q, err_q;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  req;
    logic                  req_bad;
    logic [DEPTH_LOG2-1:0] req_idx;

    // Attributes of the access about to enter RESP; with zero wait states it
    // comes straight from the inputs, otherwise from the latched request.
    logic                  resp_rd, resp_bad;
    logic [DEPTH_LOG2-1:0] resp_idx;
    logic                  busy;

    assign req     = bus.mem_read | bus.mem_write;
    assign req_idx = bus.addr[DEPTH_LOG2+1:2];

`ifdef MISALIGN_TRAP_EN
    assign req_bad = (bus.mem_read & bus.mem_write) | (bus.addr[1:0] != 2'b00);
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:DEPTH_LOG2+2];
`else
    assign req_bad = bus.mem_read & bus.mem_write;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / steering logic
    always_comb begin
        busy     = (state_q != S_IDLE);
        resp_rd  = op_rd_q;
        resp_bad = bad_q;
        resp_idx = idx_q;
        if (state_q == S_IDLE) begin
            resp_rd  = bus.mem_read;
            resp_bad = req_bad;
            resp_idx = req_idx;
        end
    end

    // Request latch, wait counter and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && req) begin
                op_rd_q <= bus.mem_read;
                op_wr_q <= bus.mem_write;
                bad_q   <= req_bad;
                idx_q   <= req_idx;
                wdata_q <= bus.wdata;
                cnt_q   <= 4'(WAIT_CYCLES);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end

            ready_q <= (state_nxt == S_RESP);
            err_q   <= (state_nxt == S_RESP) && resp_bad;
            if (state_nxt == S_RESP && resp_rd && !resp_bad) begin
                rdata_q <= mem[resp_idx];
            end
        end
    end

    // Store commits on the RESP->IDLE edge; an async reset forces IDLE first,
    // so an aborted write never reaches the array.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && op_wr_q && !bad_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy;
endmodule
